pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator: one shared period counter drives N_CH independent duty comparators. Supports edge-aligned and center-aligned modes, per-channel output polarity, and glitch-free double-buffered period/duty updates applied only at a period boundary. It replaces the single-channel fixed-period PWM and feeds motor/LED driver pins directly from the SPI-configured register block.

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_channel_cmp.sv | 38 +++
 rtl/pwm_multichannel.sv | 96 +++++++++
 tb/tb_pwm_multichannel.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode encoding and
// default geometry.
package pwm_pkg;
  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam int PWM_CNT_W      = 8;
  localparam int PWM_PERIOD_RST = 9;
endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: double-buffered duty, comparator against the shared
// counter, polarity inversion and the output register.
module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic             apply,
  input  logic             polarity,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);
  logic [CNT_W-1:0] duty_stg;
  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] duty_eff;
  logic             active;

  // On an applying boundary the new duty already governs the cnt = 0 cycle.
  assign duty_eff = apply ? duty_stg : duty_sh;
  assign active   = enable && ({1'b0, cnt} < {1'b0, duty_eff});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_stg <= '0;
      duty_sh  <= '0;
      pwm      <= 1'b0;
    end else begin
      if (load)  duty_stg <= duty_in;
      if (apply) duty_sh  <= duty_stg;
      pwm <= active ^ polarity;
    end
  end
endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared up / up-down period counter with buffered
// period and mode, driving N_CH duty comparators.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = PWM_CNT_W,
  parameter int PERIOD_RST = PWM_PERIOD_RST
) (
  input  logic                  SLK,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  center_mode,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [N_CH-1:0]       polarity,
  input  logic                  load,
  output logic [N_CH-1:0]       pwm,
  output logic                  period_start,
  output logic                  load_pending
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_stg;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_eff;
  logic             center_stg;
  logic             center_sh;
  logic             center_eff;
  logic             dir_down;
  logic             dir_nxt;
  logic             apply;

  // With enable low the counter sits at 0, so a pending load lands at once.
  assign apply      = load_pending && (!enable || (cnt == '0));
  assign period_eff = apply ? period_stg : period_sh;
  assign center_eff = apply ? center_stg : center_sh;

  always_comb begin
    cnt_nxt = '0;
    dir_nxt = 1'b0;
    if (enable && (period_eff != '0)) begin
      if (dir_down) begin
        cnt_nxt = cnt - CNT_W'(1);
        dir_nxt = (cnt != CNT_W'(1));
      end else if (cnt < period_eff) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else if (center_eff == PWM_CENTER) begin
        cnt_nxt = period_eff - CNT_W'(1);
        dir_nxt = (cnt_nxt != '0);
      end
    end
  end

  always_ff @(posedge SLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir_down     <= 1'b0;
      period_stg   <= CNT_W'(PERIOD_RST);
      period_sh    <= CNT_W'(PERIOD_RST);
      center_stg   <= PWM_EDGE;
      center_sh    <= PWM_EDGE;
      load_pending <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      dir_down     <= dir_nxt;
      period_start <= enable && (cnt == '0);
      if (load) begin
        period_stg <= period;
        center_stg <= center_mode;
      end
      if (apply) begin
        period_sh <= period_stg;
        center_sh <= center_stg;
      end
      load_pending <= load || (load_pending && !apply);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel_cmp #(
      .CNT_W(CNT_W)
    ) u_cmp (
      .clk     (SLK),
      .rst_n   (rst_n),
      .enable  (enable),
      .load    (load),
      .apply   (apply),
      .polarity(polarity[i]),
      .duty_in (duty[i*CNT_W +: CNT_W]),
      .cnt     (cnt),
      .pwm     (pwm[i])
    );
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: directed scenarios plus random traffic, all
// compared cycle by cycle against a phase-based reference model.
module tb_pwm_multichannel;
  localparam int N_CH       = 4;
  localparam int CNT_W      = 8;
  localparam int PERIOD_RST = 9;

  logic                  SLK = 1'b0;
  logic                  rst_n;
  logic                  enable;
  logic                  center_mode;
  logic [CNT_W-1:0]      period;
  logic [N_CH*CNT_W-1:0] duty;
  logic [N_CH-1:0]       polarity;
  logic                  load;
  logic [N_CH-1:0]       pwm;
  logic                  period_start;
  logic                  load_pending;

  pwm_multichannel #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD_RST(PERIOD_RST)
  ) dut (
    .SLK(SLK), .rst_n(rst_n), .enable(enable), .center_mode(center_mode),
    .period(period), .duty(duty), .polarity(polarity), .load(load),
    .pwm(pwm), .period_start(period_start), .load_pending(load_pending)
  );

  always #5 SLK = ~SLK;

  int    n_chk = 0;
  int    n_err = 0;
  string cur_tag = "init";

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", cur_tag, tag, obs, exp, $time);
    end
  endtask

  // Reference model: position within the cycle (phase) plus buffered settings.
  int m_phase, m_per_sh, m_per_stg;
  bit m_c_sh, m_c_stg, m_lp;
  int m_d_sh[N_CH];
  int m_d_stg[N_CH];

  function automatic int cnt_of(int ph, int p, bit c);
    if (!c) return ph;
    return (ph <= p) ? ph : 2 * p - ph;
  endfunction

  function automatic int len_of(int p, bit c);
    if (!c) return p + 1;
    return (p == 0) ? 1 : 2 * p;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_per_sh = PERIOD_RST; m_per_stg = PERIOD_RST;
    m_c_sh = 0; m_c_stg = 0; m_lp = 0;
    for (int i = 0; i < N_CH; i++) begin m_d_sh[i] = 0; m_d_stg[i] = 0; end
  endtask

  task automatic step();
    int cnt, peff;
    bit ap, ceff, en, ld, c_in;
    int deff[N_CH];
    int d_in[N_CH];
    int p_in;
    logic [N_CH-1:0] e_pwm;
    bit e_ps;
    en = enable; ld = load; c_in = center_mode; p_in = int'(period);
    for (int i = 0; i < N_CH; i++) d_in[i] = int'(duty[i*CNT_W +: CNT_W]);
    cnt  = cnt_of(m_phase, m_per_sh, m_c_sh);
    ap   = m_lp && (!en || cnt == 0);
    peff = ap ? m_per_stg : m_per_sh;
    ceff = ap ? m_c_stg : m_c_sh;
    for (int i = 0; i < N_CH; i++) begin
      deff[i]  = ap ? m_d_stg[i] : m_d_sh[i];
      e_pwm[i] = (en && cnt < deff[i]) ^ polarity[i];
    end
    e_ps = en && cnt == 0;
    @(posedge SLK);
    #1;
    check_val("pwm", 32'(pwm), 32'(e_pwm));
    check_val("period_start", 32'(period_start), 32'(e_ps));
    check_val("load_pending", 32'(load_pending), 32'(ld || (m_lp && !ap)));
    m_per_sh = peff; m_c_sh = ceff;
    for (int i = 0; i < N_CH; i++) m_d_sh[i] = deff[i];
    if (ld) begin
      m_per_stg = p_in; m_c_stg = c_in;
      for (int i = 0; i < N_CH; i++) m_d_stg[i] = d_in[i];
    end
    m_lp    = ld || (m_lp && !ap);
    m_phase = en ? (m_phase + 1) % len_of(peff, ceff) : 0;
  endtask

  task automatic set_duty(input int ch, input int v);
    duty[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic load_step();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_to_phase(input int ph);
    for (int k = 0; k < 600 && m_phase != ph; k++) step();
    check_val("phase_reach", 32'(m_phase), 32'(ph));
  endtask

  task automatic count_cycles(input int n, output int hi, output int ps);
    hi = 0; ps = 0;
    for (int k = 0; k < n; k++) begin
      step();
      hi += int'(pwm[0]);
      ps += int'(period_start);
    end
  endtask

  int hi, ps;

  initial begin
    rst_n = 1'b0; enable = 1'b0; center_mode = 1'b0; period = '0;
    duty = '0; polarity = '0; load = 1'b0;
    #12;
    cur_tag = "reset";
    check_val("pwm", 32'(pwm), 32'h0);
    check_val("period_start", 32'(period_start), 32'h0);
    check_val("load_pending", 32'(load_pending), 32'h0);
    model_reset();
    rst_n = 1'b1;

    cur_tag = "edge";
    enable = 1'b1; period = 8'd9; center_mode = 1'b0;
    set_duty(0, 3); set_duty(1, 5); set_duty(2, 0); set_duty(3, 10);
    load_step();
    run_to_phase(0);
    count_cycles(10, hi, ps);
    check_val("edge_hi", 32'(hi), 32'd3);
    check_val("edge_ps", 32'(ps), 32'd1);

    cur_tag = "center";
    period = 8'd4; center_mode = 1'b1; set_duty(0, 2);
    load_step();
    run_to_phase(0);
    run_to_phase(0);
    count_cycles(8, hi, ps);
    check_val("center_ps", 32'(ps), 32'd1);

    cur_tag = "midload";
    period = 8'd9; center_mode = 1'b0; set_duty(0, 3);
    load_step();
    run_to_phase(0);
    run_to_phase(4);
    set_duty(0, 7);
    load_step();
    run_to_phase(0);
    count_cycles(10, hi, ps);
    check_val("midload_hi", 32'(hi), 32'd7);

    cur_tag = "bndload";
    set_duty(0, 5);
    load_step();
    count_cycles(9, hi, ps);
    check_val("bndload_old_hi", 32'(hi), 32'd6);
    count_cycles(10, hi, ps);
    check_val("bndload_new_hi", 32'(hi), 32'd5);
    run_to_phase(2);
    set_duty(0, 4);
    load_step();
    run_to_phase(5);
    set_duty(0, 6);
    load_step();
    run_to_phase(0);
    count_cycles(10, hi, ps);
    check_val("lastload_hi", 32'(hi), 32'd6);

    cur_tag = "extremes";
    set_duty(0, 0); set_duty(1, 10);
    polarity = 4'b0011;
    load_step();
    run_to_phase(0);
    step();
    for (int k = 0; k < 25; k++) begin
      step();
      check_val("extreme_pins", 32'(pwm[1:0]), 32'h1);
    end

    cur_tag = "midreset";
    polarity = '0;
    run_to_phase(5);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_pwm", 32'(pwm), 32'h0);
    check_val("rst_ps", 32'(period_start), 32'h0);
    check_val("rst_lp", 32'(load_pending), 32'h0);
    model_reset();
    @(negedge SLK);
    rst_n = 1'b1;
    count_cycles(10, hi, ps);
    check_val("post_rst_hi", 32'(hi), 32'd0);
    check_val("post_rst_ps", 32'(ps), 32'd1);
    count_cycles(10, hi, ps);
    check_val("post_rst_ps2", 32'(ps), 32'd1);

    cur_tag = "random";
    for (int k = 0; k < 1500; k++) begin
      enable = ($urandom_range(0, 15) != 0);
      load   = ($urandom_range(0, 11) == 0);
      if (load) begin
        center_mode = 1'($urandom_range(0, 1));
        period = ($urandom_range(0, 19) == 0) ? 8'd254 : 8'($urandom_range(0, 12));
        for (int i = 0; i < N_CH; i++)
          set_duty(i, ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 14)));
      end
      if ($urandom_range(0, 19) == 0) polarity = 4'($urandom);
      step();
      load = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
